// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Reusable pipeline stage register with a valid/ready handshake, flush,
// bubble insertion and a saturating stall counter. It can sit at any
// boundary in the core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Build option:
//   PIPE_SKID_EN  - when defined, a second (skid) entry is built. in_ready is
//                   then purely registered (!skid_valid), so full throughput
//                   survives a one-cycle downstream stall without a
//                   combinational out_ready -> in_ready path. When undefined,
//                   the stage holds a single entry and in_ready is
//                   !main_valid | out_ready.
//
// Parameters:
//   DATA_W  payload width in bits
//   BUBBLE  payload loaded on reset and on flush
//   CNT_W   width of the saturating stall counter
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   flush      synchronous kill of all held entries
//   in_valid   upstream payload valid
//   in_ready   stage can accept this cycle
//   in_data    upstream payload
//   out_valid  stage holds a valid payload
//   out_ready  downstream accepts this cycle
//   out_data   payload presented downstream (qualify with out_valid)
//   stall_cnt  cycles with out_valid & !out_ready, saturating
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned       DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              main_valid;
    logic              accept;
    logic              drain;

    // The entry valid bits are decoded from the state, so they can never
    // disagree with it.
    assign main_valid = (state_q != EMPTY);

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_valid;

    assign skid_valid = (state_q == FULL2);
    // Registered ready: depends only on state, never on out_ready.
    assign in_ready   = !skid_valid;
`else
    // Single entry: a full stage can still accept when it drains this cycle.
    assign in_ready   = !main_valid || out_ready;
`endif

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        main_data_d = main_data_q;
`ifdef PIPE_SKID_EN
        skid_data_d = skid_data_q;
`endif

        if (flush) begin
            // Flush wins over accept and drain; any input taken this cycle
            // is dropped.
            state_d     = EMPTY;
            main_data_d = BUBBLE;
`ifdef PIPE_SKID_EN
            skid_data_d = BUBBLE;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = FULL1;
                        main_data_d = in_data;
                    end
                end
                FULL1: begin
                    if (accept && drain) begin
                        main_data_d = in_data;
`ifdef PIPE_SKID_EN
                    end else if (accept) begin
                        state_d     = FULL2;
                        skid_data_d = in_data;
`endif
                    end else if (drain) begin
                        // main_data keeps the drained payload; out_valid=0
                        // tells downstream to ignore it.
                        state_d = EMPTY;
                    end
                end
`ifdef PIPE_SKID_EN
                FULL2: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        state_d     = FULL1;
                        main_data_d = skid_data_q;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            state_q     <= EMPTY;
            // NOTE: the payload registers are reset on purpose: downstream
            // sees a defined BUBBLE on out_data straight out of reset.
            main_data_q <= BUBBLE;
`ifdef PIPE_SKID_EN
            skid_data_q <= BUBBLE;
`endif
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
`ifdef PIPE_SKID_EN
            skid_data_q <= skid_data_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Stall counter: counts on current outputs (including a flush cycle),
    // saturates, and is cleared only by reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg (either build). A queue model of the
// stage is compared against the DUT on every negative clock edge; a few
// hand-computed literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;
    localparam logic [DATA_W-1:0] BUBBLE  = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [CNT_W-1:0]  CNT_MAX = 4'hF;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: the stage is a FIFO of capacity 2 (skid) or 1.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_last;
    int                m_cnt;
    bit                model_ok = 1'b0;

    function automatic bit m_in_ready();
`ifdef PIPE_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || out_ready;
`endif
    endfunction

    always @(posedge clk) begin
        bit                m_acc;
        bit                m_drn;
        logic [DATA_W-1:0] popped;
        if (reset) begin
            mq.delete();
            m_last   = BUBBLE;
            m_cnt    = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_acc = in_valid && m_in_ready();
            m_drn = (mq.size() > 0) && out_ready;
            if ((mq.size() > 0) && !out_ready && (m_cnt < int'(CNT_MAX)))
                m_cnt++;
            if (flush) begin
                mq.delete();
                m_last = BUBBLE;
            end else begin
                if (m_drn) begin
                    popped = mq.pop_front();
                    if (mq.size() == 0) m_last = popped;
                end
                if (m_acc) mq.push_back(in_data);
            end
        end
    end

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (model_ok) begin
            check("cmp_out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("cmp_out_data", out_data, (mq.size() > 0) ? mq[0] : m_last);
            check("cmp_in_ready", 64'(in_ready), 64'(m_in_ready()));
            check("cmp_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        end
    end

    // -------------------------------------------------------------------------
    // Source: presents payloads in order and only advances on a handshake.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] src[0:31];
    int src_n   = 0;
    int src_idx = 0;

    task automatic push_src(input logic [DATA_W-1:0] v);
        src[src_n] = v;
        src_n++;
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic cyc(input bit offer, input bit ordy, input bit fl, input bit rst);
        bit took;
        in_valid  = offer && (src_idx < src_n) && !rst;
        in_data   = in_valid ? src[src_idx] : 64'h5A5A_5A5A_5A5A_5A5A;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #2;
        took = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (took) src_idx++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'hDEAD_BEEF_0BAD_F00D);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Stream with out_ready=1
        push_src(64'h0000_0004_0000_0013);
        push_src(64'h0000_0008_0000_0013);
        push_src(64'h0000_000C_0000_0013);
        cyc(1, 1, 0, 0);
        check("stream_first_data", out_data, 64'h0000_0004_0000_0013);
        check("stream_first_valid", 64'(out_valid), 64'd1);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check("stream_third_data", out_data, 64'h0000_000C_0000_0013);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("stream_stall_cnt", 64'(stall_cnt), 64'd0);
        check("stream_drained_valid", 64'(out_valid), 64'd0);

        // Back-pressure: drop out_ready for one cycle while A is shown
        push_src(64'hAAAA_0000_0000_0001);
        push_src(64'hBBBB_0000_0000_0002);
        push_src(64'hCCCC_0000_0000_0003);
        cyc(1, 1, 0, 0);
        check("bp_a_shown", out_data, 64'hAAAA_0000_0000_0001);
        cyc(1, 0, 0, 0);
        check("bp_a_held", out_data, 64'hAAAA_0000_0000_0001);
        repeat (4) cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("bp_stall_cnt", 64'(stall_cnt), 64'd1);
        check("bp_all_sent", 64'(src_idx), 64'd6);

        // Flush with the stage full and an input presented
        push_src(64'hD000_0000_0000_000D);
        push_src(64'hE000_0000_0000_000E);
        push_src(64'hF000_0000_0000_000F);
        push_src(64'h1000_0000_0000_0001);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_data", out_data, 64'hDEAD_BEEF_0BAD_F00D);
        check("flush_stall_cnt", 64'(stall_cnt), 64'd3);
        repeat (3) cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        // Flush in a cycle where the input is accepted: it is dropped.
        push_src(64'h2000_0000_0000_0002);
        push_src(64'h3000_0000_0000_0003);
        push_src(64'h4000_0000_0000_0004);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        check("flush_acc_valid", 64'(out_valid), 64'd0);
        cyc(1, 1, 0, 0);
        check("flush_next_data", out_data, 64'h4000_0000_0000_0004);
        cyc(0, 1, 0, 0);

        // Stall saturation
        push_src(64'h5000_0000_0000_0005);
        cyc(1, 1, 0, 0);
        repeat (20) cyc(0, 0, 0, 0);
        check("sat_stall_cnt", 64'(stall_cnt), 64'd15);
        check("sat_held_data", out_data, 64'h5000_0000_0000_0005);
        cyc(0, 0, 1, 0);
        check("sat_after_flush", 64'(stall_cnt), 64'd15);
        cyc(0, 0, 0, 1);
        check("sat_after_reset", 64'(stall_cnt), 64'd0);

        // Reset mid-stream with the stage full
        push_src(64'h6000_0000_0000_0006);
        push_src(64'h7000_0000_0000_0007);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", out_data, 64'hDEAD_BEEF_0BAD_F00D);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
